// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter that sequences Avalon-MM accesses onto a
// single-port synchronous RAM (address registered in the RAM, q one cycle later).
module onchip_mem_arbiter #(
  parameter int          ADDR_W     = 10,
  parameter int          DATA_W     = 32,
  parameter int          BE_W       = 4,
  parameter logic [15:0] CNT_PRESET = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [15:0]       conflict_count
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RDATA = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d, rr_last_q, rr_last_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              cs_q, cs_d, we_q, we_d;
  logic              m0_wait_q, m0_wait_d, m1_wait_q, m1_wait_d;
  logic              m0_rdv_q, m0_rdv_d, m1_rdv_q, m1_rdv_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              m0_req_s, m1_req_s, win_s;

  assign m0_req_s = m0_read | m0_write;
  assign m1_req_s = m1_read | m1_write;
  // Under contention the master that did not win last time goes first.
  assign win_s    = (m0_req_s && m1_req_s) ? ~rr_last_q : m1_req_s;

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      rr_last_q  <= 1'b1;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      cnt_q      <= CNT_PRESET;
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      m0_wait_q  <= 1'b1;
      m1_wait_q  <= 1'b1;
      m0_rdv_q   <= 1'b0;
      m1_rdv_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_last_q  <= rr_last_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      we_q       <= we_d;
      m0_wait_q  <= m0_wait_d;
      m1_wait_q  <= m1_wait_d;
      m0_rdv_q   <= m0_rdv_d;
      m1_rdv_q   <= m1_rdv_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Next-state logic: arbitration, request capture and conflict counting.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req_s || m1_req_s) begin
          state_d   = S_ACCESS;
          gnt_d     = win_s;
          rr_last_d = win_s;
          wr_d      = win_s ? m1_write      : m0_write;
          addr_d    = win_s ? m1_address    : m0_address;
          be_d      = win_s ? m1_byteenable : m0_byteenable;
          wdata_d   = win_s ? m1_writedata  : m0_writedata;
          if (m0_req_s && m1_req_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (wr_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RDATA;
        end
      end
      S_RDATA: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every handshake output is a flop.
  always_comb begin
    cs_d       = (state_d == S_ACCESS);
    we_d       = (state_d == S_ACCESS) && wr_d;
    m0_wait_d  = !((state_d == S_ACCESS) && (gnt_d == 1'b0));
    m1_wait_d  = !((state_d == S_ACCESS) && (gnt_d == 1'b1));
    m0_rdv_d   = (state_d == S_RDATA) && (gnt_d == 1'b0);
    m1_rdv_d   = (state_d == S_RDATA) && (gnt_d == 1'b1);
    m0_rdata_d = m0_rdv_q ? mem_readdata : m0_rdata_q;
    m1_rdata_d = m1_rdv_q ? mem_readdata : m1_rdata_q;
  end

  // RAM q is passed straight through in the data cycle and held afterwards.
  assign m0_readdata      = m0_rdata_d;
  assign m1_readdata      = m1_rdata_d;
  assign m0_waitrequest   = m0_wait_q;
  assign m1_waitrequest   = m1_wait_q;
  assign m0_readdatavalid = m0_rdv_q;
  assign m1_readdatavalid = m1_rdv_q;
  assign mem_address      = addr_q;
  assign mem_byteenable   = be_q;
  assign mem_writedata    = wdata_q;
  assign mem_chipselect   = cs_q;
  assign mem_write        = we_q;
  assign conflict_count   = cnt_q;

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master round-robin arbiter and access sequencer for the single-port 1024x32 on-chip RAM (one-cycle registered-address read).
- Master 0 is the Nios II data master; master 1 is the polling I/O engine. Both see an Avalon-MM slave interface with waitrequest and readdatavalid.
- Serialises their accesses onto the RAM's single port (address, byteenable, chipselect, write, writedata, readdata) and returns read data to the winner.

Parameters:
- ADDR_W, 10, word address width (1024 words).
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m0_address  in  ADDR_W  master 0 word address.
- m0_byteenable  in  BE_W  master 0 byte lanes.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_readdata  out  DATA_W  master 0 read data.
- m0_waitrequest  out  1  master 0 stall.
- m0_readdatavalid  out  1  master 0 read data valid.
- m1_*  same eight signals as m0_*, for master 1.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  BE_W  RAM byte enables.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write.
- mem_writedata  out  DATA_W  RAM write data.
- mem_readdata  in  DATA_W  RAM q output, valid the cycle after the address is clocked.
- conflict_count  out  16  saturating count of cycles in which both masters requested in IDLE.

Behaviour:
- Reset (async assert, sync-free release):
  - State = IDLE; rr_last = 1, so master 0 wins first.
  - All waitrequest = 1; all readdatavalid = 0; all readdata = 0.
  - mem_chipselect = 0, mem_write = 0, mem_address/byteenable/writedata = 0.
  - conflict_count = 0.
- Request: mX_req = mX_read | mX_write. If both are asserted together, it is treated as a write; the read is ignored.
- Masters must hold request and qualifiers while waitrequest = 1. The arbiter does not check this.
- FSM states: IDLE, ACCESS, RDATA.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesting: grant the master that is not rr_last, and increment conflict_count (saturates at 0xFFFF).
  - On grant: register the winner's address, byteenable, writedata and write flag into the mem_* outputs; set gnt = winner; rr_last = winner; go to ACCESS.
- ACCESS (1 cycle):
  - mem_chipselect = 1; mem_write = registered write flag.
  - mX_waitrequest = 0 for the granted master only; this is the Avalon accept cycle.
  - Write: the RAM writes at the end of this cycle; next state IDLE. Write latency is request-to-accept 2 cycles.
  - Read: next state RDATA.
- RDATA (1 cycle):
  - mem_chipselect = 0; mem_write = 0.
  - mX_readdatavalid = 1 and mX_readdata = mem_readdata (combinational pass) for gnt.
  - Next state IDLE. Read latency: accept cycle + 1.
- Back-to-back: each access returns to IDLE, so minimum spacing is 2 cycles per write and 3 cycles per read. When both masters are continuously requesting, grants strictly alternate.
- Non-granted master: waitrequest = 1 and readdatavalid = 0 throughout.
- Registered readdata: mX_readdata holds its last value when readdatavalid = 0.
- Reset asserted mid-operation (ACCESS or RDATA): the access is aborted. The RAM may or may not complete a write already clocked. No readdatavalid is emitted after reset.
- Address wrap: none. The address passes through unmodified; 0x3FF is a legal last word.
- Byteenable = 0 on a write: the access is still sequenced and acknowledged, but no bytes change.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF at addr 0x005, BE=0xF -> m0_waitrequest low exactly in cycle 2 after the request, mem_chipselect=mem_write=1 that cycle, mem_address=0x005; conflict_count=0.
- m1 reads 0x005 after that write -> m1_waitrequest low in the ACCESS cycle, m1_readdatavalid=1 one cycle later with m1_readdata=0xDEADBEEF.
- m0 and m1 both request writes continuously from reset (m0 0x11111111@0x010, m1 0x22222222@0x011) -> grants in order m0, m1, m0, m1; conflict_count increments on each contested IDLE cycle; m0_waitrequest and m1_waitrequest are never low in the same cycle.
- m0 writes 0x00AB0000 at 0x3FF with BE=0x4 over 0xFFFFFFFF, then reads 0x3FF -> readdata=0xFFABFFFF.
- Assert reset_n=0 during the RDATA cycle of an m1 read -> all waitrequest = 1, readdatavalid stays 0, FSM returns to IDLE; after release, m0 wins the first contested grant.
- Force conflict_count to 0xFFFE via 3 contested grants from a preset test hook -> value saturates at 0xFFFF and does not wrap.
